// File: rtl/fir_stream_sequencer.sv
// Round sequencer for the FIR engine: arms on a config start, gates the X and Y AXI-Stream
// paths to exactly data_length beats each, and reports ap_start/ap_idle/ap_done status.
module fir_stream_sequencer #(
    parameter int DATA_W      = 32,
    parameter int LEN_W       = 32,
    parameter int TIMEOUT_CYC = 4096,
    parameter int RND_W       = 8
) (
    input  logic              axis_clk,
    input  logic              axis_rst_n,
    input  logic              cfg_start,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              sts_rd,
    output logic              ap_start,
    output logic              ap_idle,
    output logic              ap_done,
    output logic              err_timeout,
    output logic [RND_W-1:0]  round_cnt,
    input  logic              tap_wr_req,
    output logic              tap_wr_gnt,
    input  logic              s_x_tvalid,
    output logic              s_x_tready,
    input  logic [DATA_W-1:0] s_x_tdata,
    output logic              m_x_tvalid,
    input  logic              m_x_tready,
    output logic [DATA_W-1:0] m_x_tdata,
    output logic              m_x_tlast,
    input  logic              s_y_tvalid,
    output logic              s_y_tready,
    input  logic [DATA_W-1:0] s_y_tdata,
    output logic              m_y_tvalid,
    input  logic              m_y_tready,
    output logic [DATA_W-1:0] m_y_tdata,
    output logic              m_y_tlast
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             r_state;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_x_cnt;
    logic [LEN_W-1:0]   r_y_cnt;
    logic [31:0]        r_wdog;
    logic               r_ap_start;
    logic               r_ap_done;
    logic               r_err;
    logic               r_zero_pend;
    logic [RND_W-1:0]   r_round_cnt;

    logic w_run;
    logic w_busy;
    logic w_x_open;
    logic w_y_open;
    logic w_x_hs;
    logic w_y_hs;
    logic w_x_last;
    logic w_y_last;
    logic w_x_fin;
    logic w_y_fin;
    logic w_y_done;
    logic w_timeout;
    logic w_start_ok;

    assign w_run    = (r_state == S_RUN);
    assign w_busy   = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_x_open = w_run && (r_x_cnt < r_len);
    assign w_y_open = w_busy && (r_y_cnt < r_len);
    assign w_x_hs   = w_x_open && s_x_tvalid && m_x_tready;
    assign w_y_hs   = w_y_open && s_y_tvalid && m_y_tready;
    assign w_x_last = (r_x_cnt == r_len - LEN_W'(1));
    assign w_y_last = (r_y_cnt == r_len - LEN_W'(1));
    assign w_x_fin  = w_x_hs && w_x_last;
    assign w_y_fin  = w_y_hs && w_y_last;
    // Y may complete before the final X beat when the engine is bypassed or short-circuits
    assign w_y_done = (r_y_cnt == r_len) || w_y_fin;

    assign w_timeout = (TIMEOUT_CYC != 0) && w_busy && !w_x_hs && !w_y_hs &&
                       (r_wdog + 32'd1 == 32'(TIMEOUT_CYC));

    // A zero-length round still occupies one cycle of pending start; further starts wait for it
    assign w_start_ok = cfg_start && !r_zero_pend &&
                        ((r_state == S_IDLE) || (r_state == S_DONE));

    assign m_x_tvalid = w_x_open && s_x_tvalid;
    assign s_x_tready = w_x_open && m_x_tready;
    assign m_x_tdata  = s_x_tdata;
    assign m_x_tlast  = w_x_open && w_x_last;
    assign m_y_tvalid = w_y_open && s_y_tvalid;
    assign s_y_tready = w_y_open && m_y_tready;
    assign m_y_tdata  = s_y_tdata;
    assign m_y_tlast  = w_y_open && w_y_last;

    assign ap_start    = r_ap_start;
    assign ap_idle     = (r_state == S_IDLE) || (r_state == S_DONE);
    assign ap_done     = r_ap_done;
    assign err_timeout = r_err;
    assign round_cnt   = r_round_cnt;
    assign tap_wr_gnt  = tap_wr_req && ap_idle;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_x_cnt     <= '0;
            r_y_cnt     <= '0;
            r_wdog      <= '0;
            r_ap_start  <= 1'b0;
            r_ap_done   <= 1'b0;
            r_err       <= 1'b0;
            r_zero_pend <= 1'b0;
            r_round_cnt <= '0;
        end else begin
            // Status read clears first so that any set below in the same cycle wins
            if (sts_rd) begin
                r_ap_done <= 1'b0;
                r_err     <= 1'b0;
            end
            if (r_zero_pend) begin
                r_zero_pend <= 1'b0;
                r_ap_start  <= 1'b0;
                r_ap_done   <= 1'b1;
                r_round_cnt <= r_round_cnt + RND_W'(1);
            end
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_start_ok) begin
                        r_len      <= cfg_len;
                        r_x_cnt    <= '0;
                        r_y_cnt    <= '0;
                        r_wdog     <= '0;
                        r_ap_start <= 1'b1;
                        r_ap_done  <= 1'b0;
                        if (cfg_len == '0) begin
                            r_zero_pend <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN, S_DRAIN: begin
                    if (w_x_hs) begin
                        r_x_cnt    <= r_x_cnt + LEN_W'(1);
                        r_ap_start <= 1'b0;
                    end
                    if (w_y_hs) begin
                        r_y_cnt <= r_y_cnt + LEN_W'(1);
                    end
                    if (w_x_hs || w_y_hs) begin
                        r_wdog <= '0;
                    end else begin
                        r_wdog <= r_wdog + 32'd1;
                    end
                    if (w_timeout) begin
                        r_state    <= S_DONE;
                        r_ap_done  <= 1'b1;
                        r_err      <= 1'b1;
                        r_ap_start <= 1'b0;
                    end else if ((w_run && w_x_fin && w_y_done) ||
                                 (!w_run && w_y_fin)) begin
                        r_state     <= S_DONE;
                        r_ap_done   <= 1'b1;
                        r_round_cnt <= r_round_cnt + RND_W'(1);
                    end else if (w_run && w_x_fin) begin
                        r_state <= S_DRAIN;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_stream_sequencer.sv
// Directed bench for fir_stream_sequencer: the bench plays source, engine (X -> Y with a fixed
// XOR transform) and sink, and checks beat counts, data, tlast and status flags.
module tb_fir_stream_sequencer;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 32;
    localparam int TOUT   = 16;
    localparam int RND_W  = 8;
    localparam logic [31:0] XBASE = 32'h0000_A000;
    localparam logic [31:0] YMASK = 32'h5555_0000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cfg_start = 1'b0;
    logic [LEN_W-1:0]  cfg_len = '0;
    logic              sts_rd = 1'b0;
    logic              ap_start, ap_idle, ap_done, err_timeout;
    logic [RND_W-1:0]  round_cnt;
    logic              tap_wr_req = 1'b0;
    logic              tap_wr_gnt;
    logic              s_x_tvalid = 1'b0;
    logic              s_x_tready;
    logic [DATA_W-1:0] s_x_tdata = '0;
    logic              m_x_tvalid;
    logic              m_x_tready = 1'b0;
    logic [DATA_W-1:0] m_x_tdata;
    logic              m_x_tlast;
    logic              s_y_tvalid = 1'b0;
    logic              s_y_tready;
    logic [DATA_W-1:0] s_y_tdata = '0;
    logic              m_y_tvalid;
    logic              m_y_tready = 1'b0;
    logic [DATA_W-1:0] m_y_tdata;
    logic              m_y_tlast;

    int n_checks = 0;
    int n_errors = 0;

    fir_stream_sequencer #(
        .DATA_W(DATA_W), .LEN_W(LEN_W), .TIMEOUT_CYC(TOUT), .RND_W(RND_W)
    ) dut (
        .axis_clk(clk), .axis_rst_n(rst_n),
        .cfg_start(cfg_start), .cfg_len(cfg_len), .sts_rd(sts_rd),
        .ap_start(ap_start), .ap_idle(ap_idle), .ap_done(ap_done),
        .err_timeout(err_timeout), .round_cnt(round_cnt),
        .tap_wr_req(tap_wr_req), .tap_wr_gnt(tap_wr_gnt),
        .s_x_tvalid(s_x_tvalid), .s_x_tready(s_x_tready), .s_x_tdata(s_x_tdata),
        .m_x_tvalid(m_x_tvalid), .m_x_tready(m_x_tready), .m_x_tdata(m_x_tdata),
        .m_x_tlast(m_x_tlast),
        .s_y_tvalid(s_y_tvalid), .s_y_tready(s_y_tready), .s_y_tdata(s_y_tdata),
        .m_y_tvalid(m_y_tvalid), .m_y_tready(m_y_tready), .m_y_tdata(m_y_tdata),
        .m_y_tlast(m_y_tlast)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_round(input int len);
        cfg_start = 1'b1;
        cfg_len   = LEN_W'(len);
        tick();
        cfg_start = 1'b0;
        cfg_len   = '0;
    endtask

    task automatic pulse_sts_rd();
        sts_rd = 1'b1;
        tick();
        sts_rd = 1'b0;
    endtask

    // Drives source/engine/sink until the DUT reports idle; returns beat counts, the cycle index
    // of the last handshake and the cycle index at which idle was seen.
    task automatic run_stream(input int len, input int y_stop, input int budget,
                              output int nx, output int ny, output int last_hs, output int c);
        logic [31:0] q[$];
        nx = 0; ny = 0; last_hs = -1; c = 0;
        while (c < budget && !ap_idle) begin
            s_x_tvalid = (c % 3 != 2);
            s_x_tdata  = XBASE + 32'(nx);
            m_x_tready = 1'b1;
            s_y_tvalid = (q.size() > 0) && (ny < y_stop);
            s_y_tdata  = (q.size() > 0) ? q[0] : 32'h0;
            m_y_tready = (c % 2 == 0);
            #1;
            if (m_x_tvalid && m_x_tready) begin
                chk_eq("x_data", m_x_tdata, XBASE + 32'(nx));
                chk_eq("x_tlast", m_x_tlast, nx == len - 1);
                q.push_back(m_x_tdata ^ YMASK);
                nx++;
                last_hs = c;
            end
            if (m_y_tvalid && m_y_tready) begin
                chk_eq("y_data", m_y_tdata, (XBASE + 32'(ny)) ^ YMASK);
                chk_eq("y_tlast", m_y_tlast, ny == len - 1);
                void'(q.pop_front());
                ny++;
                last_hs = c;
            end
            @(posedge clk);
            #1;
            c++;
        end
        s_x_tvalid = 1'b0;
        s_y_tvalid = 1'b0;
        m_x_tready = 1'b0;
        m_y_tready = 1'b0;
        chk_eq("round_in_budget", c < budget, 1'b1);
    endtask

    int nx, ny, last_hs, cyc;

    initial begin
        // Reset values, with downstream ready asserted to prove the gates hold
        m_x_tready = 1'b1;
        m_y_tready = 1'b1;
        s_x_tvalid = 1'b1;
        s_y_tvalid = 1'b1;
        tick();
        tick();
        chk_eq("rst_idle", ap_idle, 1'b1);
        chk_eq("rst_start", ap_start, 1'b0);
        chk_eq("rst_done", ap_done, 1'b0);
        chk_eq("rst_err", err_timeout, 1'b0);
        chk_eq("rst_rnd", round_cnt, 0);
        chk_eq("rst_gates", {m_x_tvalid, s_x_tready, m_y_tvalid, s_y_tready}, 4'b0000);
        s_x_tvalid = 1'b0;
        s_y_tvalid = 1'b0;
        m_x_tready = 1'b0;
        m_y_tready = 1'b0;
        rst_n = 1'b1;
        tick();

        // Three back-to-back len=64 rounds
        for (int r = 1; r <= 3; r++) begin
            start_round(64);
            chk_eq("start_flag", ap_start, 1'b1);
            chk_eq("busy", ap_idle, 1'b0);
            tap_wr_req = 1'b1;
            #1;
            chk_eq("tap_gnt_run", tap_wr_gnt, 1'b0);
            // Start while busy is ignored
            start_round(3);
            chk_eq("start_kept", ap_start, 1'b1);
            run_stream(64, 1000, 2000, nx, ny, last_hs, cyc);
            chk_eq("x_beats", nx, 64);
            chk_eq("y_beats", ny, 64);
            chk_eq("done_set", ap_done, 1'b1);
            chk_eq("start_clr", ap_start, 1'b0);
            chk_eq("no_err", err_timeout, 1'b0);
            chk_eq("rnd", round_cnt, r);
            chk_eq("tap_gnt_done", tap_wr_gnt, 1'b1);
            tap_wr_req = 1'b0;
            pulse_sts_rd();
            chk_eq("done_clr", ap_done, 1'b0);
            chk_eq("idle_after_rd", ap_idle, 1'b1);
        end

        // Zero-length round: no beats, done two cycles after start
        s_x_tvalid = 1'b1;
        m_x_tready = 1'b1;
        start_round(0);
        chk_eq("z_start", ap_start, 1'b1);
        chk_eq("z_done0", ap_done, 1'b0);
        chk_eq("z_idle0", ap_idle, 1'b1);
        chk_eq("z_xgate0", m_x_tvalid, 1'b0);
        tick();
        chk_eq("z_done1", ap_done, 1'b1);
        chk_eq("z_start1", ap_start, 1'b0);
        chk_eq("z_idle1", ap_idle, 1'b1);
        chk_eq("z_rnd", round_cnt, 4);
        chk_eq("z_xgate1", m_x_tvalid, 1'b0);
        s_x_tvalid = 1'b0;
        m_x_tready = 1'b0;
        pulse_sts_rd();

        // Engine stalls after 5 Y beats: watchdog aborts 16 cycles after the last handshake
        start_round(8);
        run_stream(8, 5, 200, nx, ny, last_hs, cyc);
        chk_eq("wd_x", nx, 8);
        chk_eq("wd_y", ny, 5);
        chk_eq("wd_delay", cyc - last_hs, TOUT + 1);
        chk_eq("wd_err", err_timeout, 1'b1);
        chk_eq("wd_done", ap_done, 1'b1);
        chk_eq("wd_rnd", round_cnt, 4);
        chk_eq("wd_start", ap_start, 1'b0);
        pulse_sts_rd();
        chk_eq("wd_err_clr", err_timeout, 1'b0);
        chk_eq("wd_done_clr", ap_done, 1'b0);

        // Reset mid-round after 10 X beats
        start_round(32);
        s_x_tvalid = 1'b1;
        m_x_tready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            s_x_tdata = XBASE + 32'(i);
            tick();
        end
        chk_eq("mid_busy", ap_idle, 1'b0);
        rst_n = 1'b0;
        #1;
        chk_eq("mr_idle", ap_idle, 1'b1);
        chk_eq("mr_gates", {m_x_tvalid, s_x_tready, m_y_tvalid, s_y_tready}, 4'b0000);
        chk_eq("mr_flags", {ap_start, ap_done, err_timeout}, 3'b000);
        chk_eq("mr_rnd", round_cnt, 0);
        s_x_tvalid = 1'b0;
        m_x_tready = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        start_round(4);
        run_stream(4, 1000, 200, nx, ny, last_hs, cyc);
        chk_eq("fresh_x", nx, 4);
        chk_eq("fresh_y", ny, 4);
        chk_eq("fresh_done", ap_done, 1'b1);
        chk_eq("fresh_rnd", round_cnt, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
